// File: rtl/rv_mul_unit_pkg.sv
// Shared constants for the iterative multiplier: FSM encodings, writeback select, decode fields.
// RV_MULH_EN widens the accumulator to 64 bits so the high product word is available.
package rv_mul_unit_pkg;

    localparam logic [1:0] MUL_IDLE = 2'd0;
    localparam logic [1:0] MUL_STEP = 2'd1;
    localparam logic [1:0] MUL_DONE = 2'd2;

    localparam int MUL_LATENCY = 9;

    localparam logic [2:0] WB_MUL        = 3'd3;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;

`ifdef RV_MULH_EN
    localparam int ACC_W = 64;
`else
    localparam int ACC_W = 32;
`endif

    // Byte k[1:0] of A and half-word k[2] of B land at bit 8*k[1:0] + 16*k[2].
    function automatic logic [5:0] pp_shamt(input logic [2:0] step);
        return {1'b0, step[1:0], 3'b000} + {1'b0, step[2], 4'b0000};
    endfunction

endpackage

// File: rtl/rv_mul_unit_mult8x16.sv
// Combinational unsigned 8x16 -> 24 partial-product multiplier.
module mult8x16 (
    input  logic [7:0]  byte_i,
    input  logic [15:0] half_i,
    output logic [23:0] prod_o
);

    assign prod_o = 24'(byte_i) * 24'(half_i);

endmodule

// File: rtl/rv_mul_unit.sv
// Iterative 32x32 multiplier: eight 8x16 partial products, start-to-valid 9 cycles, start ignored while busy.
// Optional macro RV_MULH_EN adds sel_hi and a 64-bit accumulator for the high product word.
module rv_mul_unit
    import rv_mul_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef RV_MULH_EN
    input  logic        sel_hi,
`endif
    output logic        busy,
    output logic        valid,
    output logic [31:0] result
);

    logic [1:0]       state_q, state_d;
    logic [2:0]       step_q, step_d;
    logic [31:0]      a_q, b_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [31:0]      result_q, result_d;
`ifdef RV_MULH_EN
    logic             sel_hi_q;
`endif

    logic             accept;
    logic [7:0]       a_byte;
    logic [15:0]      b_half;
    logic [23:0]      pp;
    logic [ACC_W-1:0] pp_shifted;
    logic [ACC_W-1:0] acc_sum;

    assign accept = start && (state_q == MUL_IDLE || state_q == MUL_DONE);

    assign a_byte = a_q[{step_q[1:0], 3'b000} +: 8];
    assign b_half = b_q[{step_q[2], 4'b0000} +: 16];

    mult8x16 u_mult (
        .byte_i (a_byte),
        .half_i (b_half),
        .prod_o (pp)
    );

    // In the 32-bit build the shift naturally drops partial-product bits above bit 31.
    assign pp_shifted = ACC_W'(pp) << pp_shamt(step_q);
    assign acc_sum    = acc_q + pp_shifted;

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            MUL_IDLE, MUL_DONE: begin
                if (start) begin
                    state_d = MUL_STEP;
                    step_d  = 3'd0;
                    acc_d   = '0;
                end else begin
                    state_d = MUL_IDLE;
                end
            end
            MUL_STEP: begin
                acc_d  = acc_sum;
                step_d = step_q + 3'd1;
                if (step_q == 3'd7) begin
                    state_d = MUL_DONE;
`ifdef RV_MULH_EN
                    result_d = sel_hi_q ? acc_sum[63:32] : acc_sum[31:0];
`else
                    result_d = acc_sum;
`endif
                end
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MUL_IDLE;
            step_q   <= 3'd0;
            acc_q    <= '0;
            result_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
`ifdef RV_MULH_EN
            sel_hi_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            if (accept) begin
                a_q <= a;
                b_q <= b;
`ifdef RV_MULH_EN
                sel_hi_q <= sel_hi;
`endif
            end
        end
    end

    assign busy   = (state_q == MUL_STEP);
    assign valid  = (state_q == MUL_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_rv_mul_unit.sv
// Self-checking bench for rv_mul_unit: vector table, random products, timing/back-to-back/ignore/reset sequences.
module tb_rv_mul_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        sel_hi_in = 1'b0;
    logic        busy, valid;
    logic [31:0] result;

    int n_vec  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

`ifdef RV_MULH_EN
    localparam bit MULH = 1'b1;
`else
    localparam bit MULH = 1'b0;
`endif

    rv_mul_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a_in),
        .b      (b_in),
`ifdef RV_MULH_EN
        .sel_hi (sel_hi_in),
`endif
        .busy   (busy),
        .valid  (valid),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        hi;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(input logic hi, input logic [31:0] lo_w, input logic [31:0] hi_w);
        return (hi && MULH) ? hi_w : lo_w;
    endfunction

    // Scoreboard: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (valid) begin
            if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
            else check("result", result, exp_q.pop_front());
        end
    end

    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic hi);
        a_in = av;
        b_in = bv;
        sel_hi_in = hi;
        start = 1'b1;
    endtask

    task automatic run_vec(input logic [31:0] av, input logic [31:0] bv, input logic hi, input logic [31:0] exp);
        bit seen;
        @(posedge clk); #1;
        issue(av, bv, hi);
        exp_q.push_back(exp);
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (valid) seen = 1'b1;
        end
        if (!seen) check("valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'h00000003, 32'h00000005, 1'b0, 32'h0000000F, 32'h00000000};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, 32'hFFFFFFFE};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000001, 32'hFFFFFFFE};
        vecs[3] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'h242D2080, 32'h0B00EA4E};
        vecs[4] = '{32'h12345678, 32'h9ABCDEF0, 1'b1, 32'h242D2080, 32'h0B00EA4E};
        vecs[5] = '{32'h00010000, 32'h00010000, 1'b1, 32'h00000000, 32'h00000001};
        vecs[6] = '{32'hFF000000, 32'hFFFF0000, 1'b1, 32'h00000000, 32'hFEFF0100};
        vecs[7] = '{32'h00000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h00000000};

        // Reset state
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Latency and hold: busy cycles 1-8, valid at 9, result held afterwards
        @(posedge clk); #1;
        issue(32'd3, 32'd5, 1'b0);
        exp_q.push_back(32'h0000000F);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) @(posedge clk);
            @(negedge clk);
            check($sformatf("busy_c%0d", k), {31'd0, busy}, (k <= 8) ? 32'd1 : 32'd0);
            check($sformatf("valid_c%0d", k), {31'd0, valid}, (k == 9) ? 32'd1 : 32'd0);
            if (k >= 9) check($sformatf("hold_c%0d", k), result, 32'h0000000F);
        end

        // Table vectors
        foreach (vecs[i])
            run_vec(vecs[i].a, vecs[i].b, vecs[i].hi, pick(vecs[i].hi, vecs[i].exp_lo, vecs[i].exp_hi));

        // Random operands against a 64-bit reference product
        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra, rb;
            logic [63:0] prod;
            logic        rh;
            ra = $urandom;
            rb = $urandom;
            rh = 1'($urandom_range(0, 1));
            prod = 64'(ra) * 64'(rb);
            run_vec(ra, rb, rh, pick(rh, prod[31:0], prod[63:32]));
        end

        // Back-to-back: start held through DONE, second valid at cycle 18
        @(posedge clk); #1;
        issue(32'd7, 32'd6, 1'b0);
        exp_q.push_back(32'h0000002A);
        exp_q.push_back(32'h0000002A);
        for (int k = 1; k <= 19; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 10) start = 1'b0;
            if (k == 8 || k == 9 || k == 10 || k == 17 || k == 18 || k == 19)
                check($sformatf("b2b_valid_c%0d", k), {31'd0, valid}, (k == 9 || k == 18) ? 32'd1 : 32'd0);
            if (k == 10) check("b2b_busy_c10", {31'd0, busy}, 32'd1);
        end

        // Start while busy is ignored
        @(posedge clk); #1;
        issue(32'd3, 32'd5, 1'b0);
        exp_q.push_back(32'h0000000F);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) @(posedge clk);
            @(negedge clk);
            if (k == 4) issue(32'h0000DEAD, 32'h0000BEEF, 1'b1);
            if (k == 5) start = 1'b0;
            if (k == 9) check("ign_valid_c9", {31'd0, valid}, 32'd1);
            if (k == 10) check("ign_idle_c10", {30'd0, busy, valid}, 32'd0);
        end
        check("ign_result_held", result, 32'h0000000F);

        // Asynchronous reset mid-operation discards the operation
        @(posedge clk); #1;
        issue(32'h12345678, 32'h9ABCDEF0, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_valid", {31'd0, valid}, 32'd0);
        check("mid_rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        run_vec(32'h12345678, 32'h9ABCDEF0, 1'b0, 32'h242D2080);

        repeat (12) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
